// File: rtl/dff_pkg.sv
// Shared definitions for the elastic register pipeline.
package dff_pkg;

    // Width of an occupancy counter able to hold 0..depth.
    function automatic int cnt_w(int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One elastic register stage: takes upstream payload whenever it is empty or its
// downstream neighbour is taking the current contents.
module dff_pipe_stage #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             up_vld_i,
    input  logic [WIDTH-1:0] up_data_i,
    input  logic             dn_ready_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] data_o,
    output logic             ready_o
);

    logic             vld_d, vld_q;
    logic [WIDTH-1:0] data_d, data_q;

    assign ready_o = ~vld_q | dn_ready_i;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (flush_i) begin
            vld_d  = 1'b0;
            data_d = RESET_VALUE;
        end else if (ready_o) begin
            vld_d = up_vld_i;
            // Bubbles advance the valid bit only; data keeps its last payload.
            if (up_vld_i) begin
                data_d = up_data_i;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q  <= 1'b0;
            data_q <= RESET_VALUE;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;

endmodule

// File: rtl/dff_pipe.sv
// Elastic valid/ready register pipeline of DEPTH stages with synchronous flush,
// programmable reset value and occupancy count.
module dff_pipe
    import dff_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      DEPTH       = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [WIDTH-1:0]          in_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [WIDTH-1:0]          out_data_o,
    output logic [cnt_w(DEPTH)-1:0]   count_o
);

    localparam int unsigned CntW = cnt_w(DEPTH);

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] data;
    } stage_t;

    logic [DEPTH-1:0] vld_vec;
    logic [CntW-1:0]  vld_cnt;

    // Each stage keeps its own nets so the backward ready chain has no
    // self-dependent vector.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        stage_t up;
        stage_t st;
        logic   dn_ready;
        logic   rdy;

        if (k == 0) begin : g_first
            assign up = '{vld: in_valid_i, data: in_data_i};
        end else begin : g_mid
            assign up = g_stage[k-1].st;
        end

        if (k == DEPTH - 1) begin : g_last
            assign dn_ready = out_ready_i;
        end else begin : g_inner
            assign dn_ready = g_stage[k+1].rdy;
        end

        dff_pipe_stage #(
            .WIDTH      (WIDTH),
            .RESET_VALUE(RESET_VALUE)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .flush_i   (flush_i),
            .up_vld_i  (up.vld),
            .up_data_i (up.data),
            .dn_ready_i(dn_ready),
            .vld_o     (st.vld),
            .data_o    (st.data),
            .ready_o   (rdy)
        );

        assign vld_vec[k] = st.vld;
    end

    always_comb begin
        vld_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            vld_cnt = vld_cnt + CntW'(vld_vec[i]);
        end
    end

    assign in_ready_o  = g_stage[0].rdy & ~flush_i;
    assign out_valid_o = g_stage[DEPTH-1].st.vld;
    assign out_data_o  = g_stage[DEPTH-1].st.data;
    assign count_o     = vld_cnt;

    a_out_stable : assert property (@(posedge clk) disable iff (reset)
        (out_valid_o && !out_ready_i && !flush_i) |=> (out_valid_o && $stable(out_data_o)));

    a_cnt_bound : assert property (@(posedge clk) disable iff (reset)
        vld_cnt <= CntW'(DEPTH));

endmodule

// File: tb/tb_dff_pipe.sv
// Directed and random checks of dff_pipe against a queue scoreboard and an
// occupancy model.
module tb_dff_pipe;

    localparam int unsigned DEPTH = 3;
    localparam logic [7:0]  RV_A  = 8'h5A;

    logic       clk = 1'b0;
    logic       reset;

    logic       a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0] a_in_data, a_out_data;
    logic [1:0] a_count;

    logic       b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [0:0] b_in_data, b_out_data;
    logic [0:0] b_count;

    int         total = 0;
    int         bad   = 0;
    int         occ   = 0;
    int         cyc   = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    dff_pipe #(
        .WIDTH      (8),
        .DEPTH      (DEPTH),
        .RESET_VALUE(RV_A)
    ) u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (a_flush),
        .in_valid_i (a_in_valid),
        .in_ready_o (a_in_ready),
        .in_data_i  (a_in_data),
        .out_valid_o(a_out_valid),
        .out_ready_i(a_out_ready),
        .out_data_o (a_out_data),
        .count_o    (a_count)
    );

    dff_pipe #(
        .WIDTH      (1),
        .DEPTH      (1),
        .RESET_VALUE(1'b1)
    ) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (b_flush),
        .in_valid_i (b_in_valid),
        .in_ready_o (b_in_ready),
        .in_data_i  (b_in_data),
        .out_valid_o(b_out_valid),
        .out_ready_i(b_out_ready),
        .out_data_o (b_out_data),
        .count_o    (b_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of dut A, entered and left at a falling edge.
    task automatic cycle(input bit iv, input logic [7:0] id, input bit ordy, input bit fl,
                         output bit acc, output bit del);
        logic exp_rdy;
        a_in_valid  = iv;
        a_in_data   = id;
        a_out_ready = ordy;
        a_flush     = fl;
        #1;
        exp_rdy = !((occ == DEPTH) && !ordy) && !fl;
        chk("in_ready", 32'(a_in_ready), 32'(exp_rdy));
        chk("count", 32'(a_count), 32'(occ));
        acc = iv && (a_in_ready === 1'b1);
        del = (a_out_valid === 1'b1) && ordy;
        if (del) begin
            if (sb.size() == 0) chk("spurious_out", 32'(a_out_valid), 32'd0);
            else chk("out_data", 32'(a_out_data), 32'(sb.pop_front()));
        end
        if (acc) sb.push_back(id);
        occ = occ + int'(acc) - int'(del);
        if (fl) begin
            occ = 0;
            sb.delete();
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit   acc, del;
        int   c, first_in, first_out, last_out, nout, nacc;
        logic b_prev;

        reset = 1'b1;
        a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_a_valid", 32'(a_out_valid), 32'd0);
        chk("rst_a_count", 32'(a_count), 32'd0);
        chk("rst_a_data", 32'(a_out_data), 32'(RV_A));
        chk("rst_a_in_ready", 32'(a_in_ready), 32'd1);
        chk("rst_b_data", 32'(b_out_data), 32'd1);
        chk("rst_b_count", 32'(b_count), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back streaming
        first_in = -1; first_out = -1; last_out = -1; nout = 0;
        for (int i = 0; i < 24; i++) begin
            c = cyc;
            cycle(i < 16, 8'(i + 1), 1'b1, 1'b0, acc, del);
            if (acc && first_in < 0) first_in = c;
            if (del) begin
                if (first_out < 0) first_out = c;
                last_out = c;
                nout++;
            end
        end
        chk("stream_latency", 32'(first_out - first_in), 32'd3);
        chk("stream_beats", 32'(nout), 32'd16);
        chk("stream_gapless", 32'(last_out - first_out), 32'd15);
        chk("stream_drained", 32'(sb.size()), 32'd0);

        // Backpressure
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, acc, del);
            if (acc) nacc++;
            if (a_out_valid === 1'b1) chk("bp_hold", 32'(a_out_data), 32'hA0);
        end
        chk("bp_accepts", 32'(nacc), 32'd3);
        chk("bp_count", 32'(a_count), 32'd3);
        chk("bp_in_ready", 32'(a_in_ready), 32'd0);
        chk("bp_out_valid", 32'(a_out_valid), 32'd1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc, del);
        chk("bp_drained", 32'(sb.size()), 32'd0);

        // Asynchronous reset with beats in flight
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, acc, del);
        chk("rst_pre_count", 32'(a_count), 32'd3);
        a_in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(a_out_valid), 32'd0);
        chk("rst_mid_count", 32'(a_count), 32'd0);
        chk("rst_mid_data", 32'(a_out_data), 32'(RV_A));
        sb.delete();
        occ = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, acc, del);
            chk("rst_no_pulse", 32'(a_out_valid), 32'd0);
        end

        // Random stalls
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) != 0, 1'b0,
                  acc, del);
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc, del);
        chk("rand_drained", 32'(sb.size()), 32'd0);

        // Flush with two beats inside; the head beat leaves in the flush cycle
        cycle(1'b1, 8'h31, 1'b0, 1'b0, acc, del);
        cycle(1'b1, 8'h32, 1'b0, 1'b0, acc, del);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, acc, del);
        chk("fl_pre_count", 32'(a_count), 32'd2);
        nout = 0;
        cycle(1'b1, 8'h33, 1'b1, 1'b1, acc, del);
        if (del) nout++;
        chk("fl_delivered", 32'(nout), 32'd1);
        chk("fl_count", 32'(a_count), 32'd0);
        chk("fl_valid", 32'(a_out_valid), 32'd0);
        chk("fl_data", 32'(a_out_data), 32'(RV_A));
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc, del);

        // WIDTH=1 DEPTH=1: in and out handshake together every cycle
        b_prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b_in_valid  = 1'b1;
            b_in_data   = 1'(i % 3 == 0);
            b_out_ready = 1'b1;
            #1;
            chk("b_in_ready", 32'(b_in_ready), 32'd1);
            chk("b_count", 32'(b_count), 32'(i > 0));
            if (i > 0) begin
                chk("b_out_valid", 32'(b_out_valid), 32'd1);
                chk("b_out_data", 32'(b_out_data), 32'(b_prev));
            end
            b_prev = b_in_data;
            @(posedge clk);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
